// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: one requester owns the 64-bit datapath from its
// header word through its EOP word, so packets never interleave. Output is registered.
module pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_INPUTS = 4,
    parameter int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_INPUTS-1:0]            in_wr,
    output logic [NUM_INPUTS-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [IDX_WIDTH-1:0]             cur_grant,
    output logic                             pkt_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]            state_q,    state_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [IDX_WIDTH-1:0]  grant_q,    grant_d;
    logic                  in_body_q,  in_body_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic                  out_wr_q,   out_wr_d;
    logic                  pkt_done_q, pkt_done_d;

    int                    cand_s;
    logic [IDX_WIDTH-1:0]  arb_idx_s;
    logic                  arb_hit_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [CTRL_WIDTH-1:0] sel_ctrl_s;
    logic                  sel_wr_s;
    logic                  xfer_s;
    logic                  eop_s;

    // Round-robin search: first requesting input at or after rr_ptr, wrapping.
    always_comb begin
        cand_s    = 0;
        arb_idx_s = rr_ptr_q;
        arb_hit_s = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cand_s = (int'(rr_ptr_q) + i) % NUM_INPUTS;
            if (!arb_hit_s && in_wr[IDX_WIDTH'(cand_s)]) begin
                arb_hit_s = 1'b1;
                arb_idx_s = IDX_WIDTH'(cand_s);
            end else begin
                arb_idx_s = arb_idx_s;
            end
        end
    end

    // Granted-input mux and ready fan-out as AND-OR so no priority is implied.
    always_comb begin
        sel_data_s = '0;
        sel_ctrl_s = '0;
        sel_wr_s   = 1'b0;
        in_rdy     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            sel_data_s = sel_data_s | (in_data[i*DATA_WIDTH +: DATA_WIDTH] &
                                       {DATA_WIDTH{grant_q == IDX_WIDTH'(i)}});
            sel_ctrl_s = sel_ctrl_s | (in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH] &
                                       {CTRL_WIDTH{grant_q == IDX_WIDTH'(i)}});
            sel_wr_s   = sel_wr_s | (in_wr[i] & (grant_q == IDX_WIDTH'(i)));
            in_rdy[i]  = (state_q == ST_XFER) && out_rdy && (grant_q == IDX_WIDTH'(i));
        end
    end

    assign xfer_s = (state_q == ST_XFER) && out_rdy && sel_wr_s;
    // A non-zero ctrl word only ends the packet once the body has started.
    assign eop_s  = xfer_s && (sel_ctrl_s != '0) && in_body_q;

    // Next-state: FSM, round-robin pointer, framing and output register staging.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        in_body_d  = xfer_s ? (sel_ctrl_s == '0) : in_body_q;
        out_wr_d   = xfer_s;
        pkt_done_d = eop_s;
        if (xfer_s) begin
            out_data_d = sel_data_s;
            out_ctrl_d = sel_ctrl_s;
        end else begin
            out_data_d = out_data_q;
            out_ctrl_d = out_ctrl_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (arb_hit_s) begin
                    grant_d = arb_idx_s;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (eop_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == IDX_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant_q + 1'b1;
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            in_body_q  <= 1'b0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
            out_wr_q   <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            in_body_q  <= in_body_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
            out_wr_q   <= out_wr_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_wr    = out_wr_q;
    assign pkt_done  = pkt_done_q;
    assign cur_grant = grant_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: single grant, round-robin fairness, backpressure,
// mid-packet gaps, reset mid-packet and wrap-around search.
module tb_pkt_rr_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int N  = 4;

    logic            clk;
    logic            reset;
    logic [N*DW-1:0] in_data;
    logic [N*CW-1:0] in_ctrl;
    logic [N-1:0]    in_wr;
    logic [N-1:0]    in_rdy;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ctrl;
    logic            out_wr;
    logic            out_rdy;
    logic [1:0]      cur_grant;
    logic            pkt_done;

    int total_cnt = 0;
    int bad_cnt   = 0;

    pkt_rr_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(N)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .cur_grant(cur_grant), .pkt_done(pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input int i, input int w);
        return {8'hA0 + 8'(i), 40'h0, 16'(w)};
    endfunction

    function automatic logic [7:0] ctrl_of(input int w, input int len);
        if (w == 0) return 8'hFF;
        else if (w == len - 1) return 8'h04;
        else return 8'h00;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int i, input int w, input logic [7:0] c);
        in_data[i*DW +: DW] = mkdata(i, w);
        in_ctrl[i*CW +: CW] = c;
    endtask

    function automatic logic [79:0] outs();
        return 80'({pkt_done, out_wr, out_ctrl, out_data});
    endfunction

    function automatic logic [79:0] exp_outs(input logic d, input logic w, input logic [7:0] c,
                                              input logic [63:0] x);
        return 80'({d, w, c, x});
    endfunction

    task automatic reset_dut();
        in_wr   = 4'b0000;
        out_rdy = 1'b1;
        reset   = 1'b1;
        cyc();
        cyc();
        reset   = 1'b0;
    endtask

    // Sends a whole packet from src and checks each word one cycle after its accept.
    task automatic xfer_pkt(input int src, input int len, input logic [3:0] mask);
        int guard;
        in_wr = mask;
        for (int w = 0; w < len; w++) begin
            present(src, w, ctrl_of(w, len));
            #1;
            guard = 0;
            while (!in_rdy[src] && guard < 16) begin
                cyc();
                guard++;
            end
            if (guard >= 16) begin
                check_val($sformatf("rdy_timeout_s%0d_w%0d", src, w), 80'(in_rdy[src]), 80'd1);
                return;
            end
            cyc();
            check_val($sformatf("pkt_s%0d_w%0d", src, w), outs(),
                      exp_outs(w == len - 1, 1'b1, ctrl_of(w, len), mkdata(src, w)));
        end
    endtask

    initial begin
        logic [N-1:0]  acc;
        int            cnt [N];
        int            p, r, wn, ones;
        logic [63:0]   hd;
        logic [7:0]    hc;

        in_data = '0;
        in_ctrl = '0;
        in_wr   = '0;
        out_rdy = 1'b1;
        reset   = 1'b1;

        // 1: reset state, single packet on input 2
        reset_dut();
        #1;
        check_val("rst_outs", outs(), 80'd0);
        check_val("rst_grant", 80'(cur_grant), 80'd0);
        check_val("rst_rdy", 80'(in_rdy), 80'd0);
        xfer_pkt(2, 5, 4'b0100);
        in_wr = 4'b0000;
        check_val("t1_grant", 80'(cur_grant), 80'd2);
        cyc();
        check_val("t1_hold", outs(), exp_outs(1'b0, 1'b0, 8'h04, mkdata(2, 4)));
        present(0, 0, 8'hFF);
        present(3, 0, 8'hFF);
        in_wr = 4'b1001;
        cyc();
        check_val("t1_rrptr3", 80'(cur_grant), 80'd3);

        // 2: all inputs request continuously, 4-word packets
        reset_dut();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        hd = '0;
        hc = '0;
        for (int e = 1; e <= 25; e++) begin
            for (int i = 0; i < N; i++) present(i, cnt[i], ctrl_of(cnt[i] % 4, 4));
            in_wr = 4'b1111;
            #1;
            acc = in_rdy;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) cnt[i]++;
                else cnt[i] = cnt[i];
            end
            p = (e - 1) / 5;
            r = (e - 1) % 5;
            if (r == 0) begin
                check_val($sformatf("rr_e%0d", e), outs(), exp_outs(1'b0, 1'b0, hc, hd));
            end else begin
                wn = (p / 4) * 4 + r - 1;
                hd = mkdata(p % 4, wn);
                hc = ctrl_of(r - 1, 4);
                check_val($sformatf("rr_e%0d", e), outs(), exp_outs(r == 4, 1'b1, hc, hd));
            end
        end

        // 3: backpressure mid-packet on input 0 with input 1 waiting
        reset_dut();
        present(0, 0, ctrl_of(0, 5));
        present(1, 0, 8'hFF);
        in_wr = 4'b0011;
        cyc();
        check_val("t3_grant0", 80'(cur_grant), 80'd0);
        cyc();
        present(0, 1, ctrl_of(1, 5));
        cyc();
        present(0, 2, ctrl_of(2, 5));
        out_rdy = 1'b0;
        #1;
        check_val("t3_rdy_drop", 80'(in_rdy), 80'd0);
        check_val("t3_extra", outs(), exp_outs(1'b0, 1'b1, 8'h00, mkdata(0, 1)));
        ones = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            ones += int'(out_wr);
        end
        check_val("t3_stall_wr", 80'(ones), 80'd0);
        check_val("t3_stall_hold", outs(), exp_outs(1'b0, 1'b0, 8'h00, mkdata(0, 1)));
        out_rdy = 1'b1;
        for (int w = 2; w < 5; w++) begin
            present(0, w, ctrl_of(w, 5));
            #1;
            check_val($sformatf("t3_rdy_w%0d", w), 80'(in_rdy), 80'd1);
            cyc();
            check_val($sformatf("t3_out_w%0d", w), outs(),
                      exp_outs(w == 4, 1'b1, ctrl_of(w, 5), mkdata(0, w)));
        end
        cyc();
        check_val("t3_grant1", 80'({out_wr, cur_grant}), 80'd1);

        // 4: granted input pauses mid-body while input 3 requests
        reset_dut();
        present(0, 0, ctrl_of(0, 4));
        present(3, 0, 8'hFF);
        in_wr = 4'b1001;
        cyc();
        cyc();
        present(0, 1, ctrl_of(1, 4));
        cyc();
        in_wr = 4'b1000;
        ones = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            ones += int'(out_wr);
            check_val($sformatf("t4_hold_g%0d", k), 80'({in_rdy, cur_grant}), 80'h4);
        end
        check_val("t4_gap_wr", 80'(ones), 80'd0);
        in_wr = 4'b1001;
        for (int w = 2; w < 4; w++) begin
            present(0, w, ctrl_of(w, 4));
            cyc();
            check_val($sformatf("t4_out_w%0d", w), outs(),
                      exp_outs(w == 3, 1'b1, ctrl_of(w, 4), mkdata(0, w)));
        end
        cyc();
        check_val("t4_grant3", 80'(cur_grant), 80'd3);

        // 5: reset in the middle of an input 1 packet
        reset_dut();
        present(1, 0, 8'hFF);
        in_wr = 4'b0010;
        cyc();
        cyc();
        present(1, 1, 8'h00);
        cyc();
        reset = 1'b1;
        cyc();
        check_val("t5_outs", outs(), 80'd0);
        check_val("t5_grant_rdy", 80'({in_rdy, cur_grant}), 80'd0);
        reset = 1'b0;
        present(0, 0, 8'hFF);
        in_wr = 4'b0011;
        cyc();
        check_val("t5_grant0", 80'(cur_grant), 80'd0);
        xfer_pkt(0, 4, 4'b0011);

        // 6: rr_ptr=1, only input 3 requests -> wrap search, then rr_ptr back to 0
        in_wr = 4'b1000;
        xfer_pkt(3, 3, 4'b1000);
        check_val("t6_grant3", 80'(cur_grant), 80'd3);
        in_wr = 4'b1010;
        cyc();
        check_val("t6_rrptr0", 80'(cur_grant), 80'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
